bcd_entry2bin: RTL and testbench

Sequential two-digit BCD-to-binary entry converter: collects decimal digits one strobe at a time (keypad/game input side), and on an enter command converts the held tens/units pair to a 7-bit binary value with a multi-cycle shift-add multiply-by-ten. It is the inverse path to the binary-to-two-digit split feeding the seven-segment displays. It produces the binary `whole_num` that game logic compares and stores.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_reg.sv | 35 +++
 rtl/bcd_entry2bin.sv | 147 ++++++++++++++
 tb/tb_bcd_entry2bin.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD entry converter.
package bcd_pkg;

   localparam int unsigned RESULT_W = 7;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

   typedef enum logic [2:0] {
      ST_EMPTY  = 3'd0,
      ST_ONE    = 3'd1,
      ST_TWO    = 3'd2,
      ST_CONV_A = 3'd3,
      ST_CONV_B = 3'd4,
      ST_CONV_C = 3'd5
   } state_t;

endpackage

// File: rtl/bcd_digit_reg.sv
// Two-digit entry shift register (tens/units) with synchronous clear and a
// held-digit counter that saturates at two.
module bcd_digit_reg
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       load,
   input  bcd_digit_t digit_in,
   output bcd_digit_t left_digit,
   output bcd_digit_t right_digit,
   output logic [1:0] digit_cnt
);

   // Clear wins over load; a load into a full register drops the oldest digit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         left_digit  <= '0;
         right_digit <= '0;
         digit_cnt   <= 2'd0;
      end else if (clear) begin
         left_digit  <= '0;
         right_digit <= '0;
         digit_cnt   <= 2'd0;
      end else if (load) begin
         left_digit  <= right_digit;
         right_digit <= digit_in;
         if (digit_cnt != 2'd2) begin
            digit_cnt <= digit_cnt + 2'd1;
         end
      end
   end

endmodule

// File: rtl/bcd_entry2bin.sv
// Sequential two-digit BCD-to-binary entry converter.
// Digits are collected one strobe at a time; enter runs a three-cycle
// shift-add multiply-by-ten (tens*8 + tens*2 + units).
// Optional build macro: BCD_ENTRY_RANGE_CHECK_EN rejects results above MAX_VAL.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_EMPTY  | no digits held, waiting for input
// ST_ONE    | one digit held (tens is zero)
// ST_TWO    | two digits held, further digits shift the oldest out
// ST_CONV_A | acc <= tens << 3
// ST_CONV_B | acc <= acc + (tens << 1)
// ST_CONV_C | result = acc + units, publish or reject, clear digits
module bcd_entry2bin
   import bcd_pkg::*;
#(
   parameter int MAX_VAL = 99
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          digit_in,
   input  logic                digit_valid,
   input  logic                enter,
   input  logic                clear,
   output logic [3:0]          left_digit,
   output logic [3:0]          right_digit,
   output logic [1:0]          digit_cnt,
   output logic                busy,
   output logic [RESULT_W-1:0] whole_num,
   output logic                num_valid,
   output logic                err
);

`ifdef BCD_ENTRY_RANGE_CHECK_EN
   localparam bit RANGE_CHECK = 1'b1;
`else
   localparam bit RANGE_CHECK = 1'b0;
`endif

   state_t              state_q, state_d;
   logic [RESULT_W-1:0] acc_q, acc_d;
   logic [RESULT_W-1:0] whole_q, whole_d;
   logic                busy_q, busy_d;
   logic                nv_q, nv_d;
   logic                err_q, err_d;
   logic                dreg_clear, dreg_load;
   logic [RESULT_W-1:0] result;
   logic                in_range;

   bcd_digit_reg u_digit_reg (
      .clk         (clk),
      .rst         (rst),
      .clear       (dreg_clear),
      .load        (dreg_load),
      .digit_in    (digit_in),
      .left_digit  (left_digit),
      .right_digit (right_digit),
      .digit_cnt   (digit_cnt)
   );

   assign result   = acc_q + {3'b000, right_digit};
   // Without range checking every two-digit value (max 99) is accepted.
   assign in_range = !RANGE_CHECK || (int'(result) <= MAX_VAL);

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
         acc_q   <= '0;
         whole_q <= '0;
         busy_q  <= 1'b0;
         nv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         whole_q <= whole_d;
         busy_q  <= busy_d;
         nv_q    <= nv_d;
         err_q   <= err_d;
      end
   end

   // Next-state, datapath and pulse decode; strobes are only honoured while idle.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      whole_d    = whole_q;
      busy_d     = 1'b0;
      nv_d       = 1'b0;
      err_d      = 1'b0;
      dreg_clear = 1'b0;
      dreg_load  = 1'b0;
      case (state_q)
         ST_EMPTY, ST_ONE, ST_TWO: begin
            if (clear) begin
               dreg_clear = 1'b1;
               state_d    = ST_EMPTY;
            end else if (enter) begin
               if (state_q == ST_EMPTY) begin
                  err_d = 1'b1;
               end else begin
                  state_d = ST_CONV_A;
                  busy_d  = 1'b1;
               end
            end else if (digit_valid) begin
               if (digit_in > BCD_MAX_DIGIT) begin
                  err_d = 1'b1;
               end else begin
                  dreg_load = 1'b1;
                  state_d   = (state_q == ST_EMPTY) ? ST_ONE : ST_TWO;
               end
            end
         end
         ST_CONV_A: begin
            acc_d   = {left_digit, 3'b000};
            busy_d  = 1'b1;
            state_d = ST_CONV_B;
         end
         ST_CONV_B: begin
            acc_d   = acc_q + {2'b00, left_digit, 1'b0};
            busy_d  = 1'b1;
            state_d = ST_CONV_C;
         end
         ST_CONV_C: begin
            if (in_range) begin
               whole_d = result;
               nv_d    = 1'b1;
            end else begin
               err_d = 1'b1;
            end
            dreg_clear = 1'b1;
            state_d    = ST_EMPTY;
         end
         default: begin
            dreg_clear = 1'b1;
            state_d    = ST_EMPTY;
         end
      endcase
   end

   assign busy      = busy_q;
   assign whole_num = whole_q;
   assign num_valid = nv_q;
   assign err       = err_q;

endmodule

// File: tb/tb_bcd_entry2bin.sv
// Self-checking bench for bcd_entry2bin: directed sequences plus a table of
// single-cycle entry vectors. Build with BCD_ENTRY_RANGE_CHECK_EN to exercise
// the range-checked variant (MAX_VAL = 50).
module tb_bcd_entry2bin;

   localparam int MAX_VAL = 50;
`ifdef BCD_ENTRY_RANGE_CHECK_EN
   localparam bit RANGE_ON = 1'b1;
`else
   localparam bit RANGE_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] digit_in = '0;
   logic       digit_valid = 1'b0;
   logic       enter = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] left_digit, right_digit;
   logic [1:0] digit_cnt;
   logic       busy;
   logic [6:0] whole_num;
   logic       num_valid;
   logic       err;

   int checks = 0;
   int errors = 0;
   int model_whole = 0;
   int nv_count = 0;

   bcd_entry2bin #(.MAX_VAL(MAX_VAL)) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .enter       (enter),
      .clear       (clear),
      .left_digit  (left_digit),
      .right_digit (right_digit),
      .digit_cnt   (digit_cnt),
      .busy        (busy),
      .whole_num   (whole_num),
      .num_valid   (num_valid),
      .err         (err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (num_valid) nv_count++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic put_digit(input logic [3:0] d);
      digit_in    = d;
      digit_valid = 1'b1;
      tick();
      digit_valid = 1'b0;
   endtask

   // Issue enter with digits already held and follow the three-cycle conversion.
   task automatic convert(input int exp_val, input bit disturb);
      bit ok;
      int nv0;
      ok  = !RANGE_ON || (exp_val <= MAX_VAL);
      nv0 = nv_count;
      enter = 1'b1;
      tick();
      enter = 1'b0;
      check("busy_n0", busy, 1);
      if (disturb) begin
         digit_in    = 4'd3;
         digit_valid = 1'b1;
         clear       = 1'b1;
         enter       = 1'b1;
      end
      tick();
      check("busy_n1", busy, 1);
      check("nv_n1", num_valid, 0);
      tick();
      digit_valid = 1'b0;
      clear       = 1'b0;
      enter       = 1'b0;
      check("busy_n2", busy, 1);
      check("err_n2", err, 0);
      tick();
      check("busy_n3", busy, 0);
      check("cnt_n3", digit_cnt, 0);
      check("left_n3", left_digit, 0);
      check("right_n3", right_digit, 0);
      if (ok) begin
         model_whole = exp_val;
         check("nv_n3", num_valid, 1);
         check("err_n3", err, 0);
      end else begin
         check("nv_n3_rej", num_valid, 0);
         check("err_n3_rej", err, 1);
      end
      check("whole_n3", whole_num, model_whole);
      tick();
      check("nv_n4", num_valid, 0);
      check("err_n4", err, 0);
      check("nv_pulses", nv_count - nv0, ok ? 1 : 0);
   endtask

   typedef struct {
      bit         valid;
      bit         ent;
      bit         clr;
      logic [3:0] digit;
      int         e_left;
      int         e_right;
      int         e_cnt;
      int         e_err;
   } vec_t;

   vec_t vecs[10];

   initial begin
      // Entry vectors, applied from EMPTY in order.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd4,  0, 4, 1, 0};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 4'd7,  4, 7, 2, 0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 4'd12, 4, 7, 2, 1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd3,  7, 3, 2, 0};
      vecs[4] = '{1'b1, 1'b0, 1'b1, 4'd5,  0, 0, 0, 0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 0, 1};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 4'd9,  0, 9, 1, 0};
      vecs[7] = '{1'b0, 1'b1, 1'b1, 4'd0,  0, 0, 0, 0};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 4'd15, 0, 0, 0, 1};
      vecs[9] = '{1'b1, 1'b1, 1'b0, 4'd2,  0, 0, 0, 1};

      rst = 1'b0;
      tick();
      tick();
      check("rst_left", left_digit, 0);
      check("rst_right", right_digit, 0);
      check("rst_cnt", digit_cnt, 0);
      check("rst_busy", busy, 0);
      check("rst_whole", whole_num, 0);
      check("rst_nv", num_valid, 0);
      check("rst_err", err, 0);
      rst = 1'b1;
      tick();

      put_digit(4'd4);
      put_digit(4'd7);
      check("seq47_left", left_digit, 4);
      check("seq47_right", right_digit, 7);
      check("seq47_cnt", digit_cnt, 2);
      convert(47, 1'b0);

      put_digit(4'd5);
      check("seq5_cnt", digit_cnt, 1);
      check("seq5_left", left_digit, 0);
      convert(5, 1'b0);
      enter = 1'b1;
      tick();
      enter = 1'b0;
      check("empty_enter_err", err, 1);
      check("empty_enter_busy", busy, 0);
      check("empty_enter_whole", whole_num, model_whole);
      tick();
      check("empty_enter_err_drop", err, 0);

      put_digit(4'd1);
      put_digit(4'd2);
      put_digit(4'd3);
      check("wrap_left", left_digit, 2);
      check("wrap_right", right_digit, 3);
      check("wrap_cnt", digit_cnt, 2);
      convert(23, 1'b0);

      for (int i = 0; i < 10; i++) begin
         digit_in    = vecs[i].digit;
         digit_valid = vecs[i].valid;
         enter       = vecs[i].ent;
         clear       = vecs[i].clr;
         tick();
         digit_valid = 1'b0;
         enter       = 1'b0;
         clear       = 1'b0;
         check($sformatf("vec%0d_left", i), left_digit, vecs[i].e_left);
         check($sformatf("vec%0d_right", i), right_digit, vecs[i].e_right);
         check($sformatf("vec%0d_cnt", i), digit_cnt, vecs[i].e_cnt);
         check($sformatf("vec%0d_err", i), err, vecs[i].e_err);
         check($sformatf("vec%0d_busy", i), busy, 0);
         check($sformatf("vec%0d_whole", i), whole_num, model_whole);
      end
      tick();

      // Strobes during conversion must be ignored.
      put_digit(4'd8);
      put_digit(4'd1);
      convert(81, 1'b1);

      put_digit(4'd0);
      convert(0, 1'b0);

      put_digit(4'd6);
      put_digit(4'd0);
      convert(60, 1'b0);

      put_digit(4'd9);
      put_digit(4'd9);
      convert(99, 1'b0);

      // Reset while in CONV_B.
      put_digit(4'd2);
      put_digit(4'd5);
      begin
         int nv0;
         nv0 = nv_count;
         enter = 1'b1;
         tick();
         enter = 1'b0;
         tick();
         rst = 1'b0;
         #1;
         check("midrst_busy", busy, 0);
         check("midrst_whole", whole_num, 0);
         check("midrst_cnt", digit_cnt, 0);
         check("midrst_left", left_digit, 0);
         check("midrst_right", right_digit, 0);
         check("midrst_err", err, 0);
         check("midrst_nv", num_valid, 0);
         tick();
         tick();
         rst = 1'b1;
         model_whole = 0;
         tick();
         tick();
         tick();
         check("midrst_no_pulse", nv_count - nv0, 0);
         check("midrst_whole_after", whole_num, model_whole);
         check("midrst_busy_after", busy, 0);
      end

      put_digit(4'd3);
      put_digit(4'd1);
      convert(31, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
